buma_sat_stage: RTL and testbench

// Registered result stage directly downstream of the 32-bit two's-complement adder.

---
 rtl/buma_sat_stage.sv | 139 +++++++++++++
 tb/tb_buma_sat_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/buma_sat_stage.sv
// Registered result stage behind the 32-bit adder. It optionally saturates overflowed
// sums and buffers up to two results so that in_ready comes straight from a flop.
module buma_sat_stage #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_ovf_q, main_ovf_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_ovf_q, skid_ovf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept;
    logic             deliver;
    logic [WIDTH-1:0] in_data_sat;

    assign accept  = in_valid && in_ready_q;
    assign deliver = out_valid_q && out_ready;

    // A set wrapped MSB means the true sum was positive, so clamp to max positive.
    always_comb begin
        in_data_sat = in_data;
        if (SAT_EN && in_ovf) begin
            in_data_sat = in_data[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                           : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ovf_d  = main_ovf_q;
        skid_data_d = skid_data_q;
        skid_ovf_d  = skid_ovf_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_data_d = in_data_sat;
                    main_ovf_d  = in_ovf;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    main_data_d = in_data_sat;
                    main_ovf_d  = in_ovf;
                end else if (accept) begin
                    skid_data_d = in_data_sat;
                    skid_ovf_d  = in_ovf;
                    state_d     = ST_TWO;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deliver) begin
                    main_data_d = skid_data_q;
                    main_ovf_d  = skid_ovf_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    // clr wins over a same-cycle overflow accept; that event is dropped.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (accept && in_ovf) begin
            sticky_d = 1'b1;
            if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_ovf_q  <= 1'b0;
            skid_data_q <= '0;
            skid_ovf_q  <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_data_q <= main_data_d;
            main_ovf_q  <= main_ovf_d;
            skid_data_q <= skid_data_d;
            skid_ovf_q  <= skid_ovf_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = main_data_q;
    assign out_ovf    = main_ovf_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

endmodule

// File: tb/tb_buma_sat_stage.sv
// Randomized bench for buma_sat_stage: two instances (saturating and pass-through) share
// stimulus and are compared against a queue-based model of a two-entry FIFO.
module tb_buma_sat_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, out_ready, clr, in_ovf;
    logic [WIDTH-1:0] in_data;

    logic             s_in_ready, s_out_valid, s_out_ovf, s_sticky;
    logic [WIDTH-1:0] s_out_data;
    logic [CNT_W-1:0] s_count;
    logic             r_in_ready, r_out_valid, r_out_ovf, r_sticky;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_count;

    always #5 clk = ~clk;

    buma_sat_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_ovf(in_ovf), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_ovf(s_out_ovf), .ovf_sticky(s_sticky),
        .ovf_count(s_count), .clr(clr));

    buma_sat_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SAT_EN(1'b0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
        .in_data(in_data), .in_ovf(in_ovf), .out_valid(r_out_valid), .out_ready(out_ready),
        .out_data(r_out_data), .out_ovf(r_out_ovf), .ovf_sticky(r_sticky),
        .ovf_count(r_count), .clr(clr));

    int vecs = 0;
    int errs = 0;

    logic [WIDTH-1:0] q_d[$];
    bit               q_o[$];
    int               cnt_m;
    bit               sticky_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] sat_ref(logic [WIDTH-1:0] d, bit ovf, bit en);
        if (!(en && ovf)) return d;
        // the true sum's sign is the opposite of the wrapped MSB
        return d[WIDTH-1] ? 32'h7FFF_FFFF : 32'h8000_0000;
    endfunction

    task automatic model_reset();
        q_d.delete();
        q_o.delete();
        cnt_m    = 0;
        sticky_m = 1'b0;
    endtask

    task automatic check_outs();
        chk("in_ready_s", 64'(s_in_ready), 64'(q_d.size() < 2));
        chk("in_ready_r", 64'(r_in_ready), 64'(q_d.size() < 2));
        chk("out_valid",  64'(s_out_valid), 64'(q_d.size() > 0));
        if (q_d.size() > 0) begin
            chk("data_sat", 64'(s_out_data), 64'(sat_ref(q_d[0], q_o[0], 1'b1)));
            chk("data_raw", 64'(r_out_data), 64'(sat_ref(q_d[0], q_o[0], 1'b0)));
            chk("out_ovf",  64'(s_out_ovf), 64'(q_o[0]));
        end
        chk("sticky", 64'(s_sticky), 64'(sticky_m));
        chk("count",  64'(s_count), 64'(cnt_m));
    endtask

    // One clock: check settled outputs, drive new inputs, advance the model at the edge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic io,
                        input logic ordy, input logic c);
        bit acc, dlv;
        @(negedge clk);
        check_outs();
        in_valid  = iv;
        in_data   = id;
        in_ovf    = io;
        out_ready = ordy;
        clr       = c;
        acc = iv && (q_d.size() < 2);
        dlv = ordy && (q_d.size() > 0);
        @(posedge clk);
        if (dlv) begin
            void'(q_d.pop_front());
            void'(q_o.pop_front());
        end
        if (acc) begin
            q_d.push_back(id);
            q_o.push_back(io);
        end
        if (c) begin
            cnt_m    = 0;
            sticky_m = 1'b0;
        end else if (acc && io) begin
            sticky_m = 1'b1;
            if (cnt_m < CNT_MAX) cnt_m++;
        end
        #1;
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; out_ready = 1'b0; clr = 1'b0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(s_out_valid), 64'd0);
        chk("rst_in_ready",  64'(s_in_ready), 64'd1);
        chk("rst_out_data",  64'(s_out_data), 64'd0);
        chk("rst_out_ovf",   64'(s_out_ovf), 64'd0);
        chk("rst_count",     64'(s_count), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // negative overflow clamps to min, positive overflow clamps to max
        step(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        chk("t1_data",   64'(s_out_data), 64'h8000_0000);
        chk("t1_ovf",    64'(s_out_ovf), 64'd1);
        chk("t1_sticky", 64'(s_sticky), 64'd1);
        chk("t1_count",  64'(s_count), 64'd1);
        step(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        chk("t2_sat", 64'(s_out_data), 64'h7FFF_FFFF);
        chk("t2_raw", 64'(r_out_data), 64'h8000_0000);
        step(1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        chk("t3_data",  64'(s_out_data), 64'd0);
        chk("t3_ovf",   64'(s_out_ovf), 64'd0);
        chk("t3_count", 64'(s_count), 64'd2);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // back-pressure: A,B fill the buffer, C waits until space frees up
        step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
        chk("t4_full", 64'(s_in_ready), 64'd0);
        step(1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0);
        chk("t4_hold", 64'(s_out_data), 64'hAAAA_0001);
        step(1'b1, 32'hCCCC_0003, 1'b0, 1'b1, 1'b0);
        chk("t4_b", 64'(s_out_data), 64'hBBBB_0002);
        step(1'b1, 32'hCCCC_0003, 1'b0, 1'b1, 1'b0);
        chk("t4_c", 64'(s_out_data), 64'hCCCC_0003);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t4_empty", 64'(s_out_valid), 64'd0);

        // counter saturation, then clr beats a simultaneous overflow accept
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        chk("t5_cnt_max", 64'(s_count), 64'(CNT_MAX));
        step(1'b1, $urandom, 1'b1, 1'b1, 1'b1);
        chk("t5_clr_cnt",    64'(s_count), 64'd0);
        chk("t5_clr_sticky", 64'(s_sticky), 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // async reset while two results are buffered
        step(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
        #1;
        chk("t6_valid",  64'(s_out_valid), 64'd0);
        chk("t6_ready",  64'(s_in_ready), 64'd1);
        chk("t6_data",   64'(s_out_data), 64'd0);
        chk("t6_sticky", 64'(s_sticky), 64'd0);
        chk("t6_count",  64'(s_count), 64'd0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 32'h3333_3333, 1'b0, 1'b1, 1'b0);
        chk("t6_post_valid", 64'(s_out_valid), 64'd1);
        chk("t6_post_data",  64'(s_out_data), 64'h3333_3333);

        for (int i = 0; i < 400; i++)
            step($urandom_range(3, 0) != 0, $urandom, $urandom_range(1, 0) == 1,
                 $urandom_range(9, 0) < 7, $urandom_range(19, 0) == 0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
